// File: rtl/pmod_ad1_capture.sv
// rtl/pmod_ad1_capture.sv - PMOD AD1 dual-channel serial capture with single-entry holding register
// Frames are committed on the first CS_N-high cycle; the word becomes visible one cycle later.
module pmod_ad1_capture #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100,
  parameter int QUIET_CYC     = 4,
  parameter int C_DATA_WIDTH  = 32
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESETN,
  input  logic                    ENABLE,
  input  logic                    CLEAR_FLAGS,
  output logic                    ADC_CS_N,
  output logic                    ADC_SCLK,
  input  logic                    ADC_D0,
  input  logic                    ADC_D1,
  output logic [C_DATA_WIDTH-1:0] SAMPLE_DATA,
  output logic                    SAMPLE_VALID,
  input  logic                    SAMPLE_READY,
  output logic                    OVERRUN,
  output logic                    FRAME_ERR,
  output logic [15:0]             SAMPLE_COUNT
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int QW    = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_QUIET,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [3:0]        slot_q;
  logic [PER_W-1:0]  period_cnt_q;
  logic [QW-1:0]     quiet_cnt_q;
  logic [15:0]       sh0_q, sh1_q;
  logic              cs_n_q, sclk_q, commit_q;
  logic [C_DATA_WIDTH-1:0] data_q;
  logic              valid_q, overrun_q, frame_err_q;
  logic [15:0]       count_q;

  logic              half_done, start_conv, end_conv, sclk_rise, sclk_fall;
  logic              lead_err, overrun_set, frame_err_set, xfer;
  logic [31:0]       word;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_conv = 1'b0;
    end_conv   = 1'b0;
    sclk_rise  = 1'b0;
    sclk_fall  = 1'b0;
    half_done  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d    = S_CONV;
          start_conv = 1'b1;
        end
      end
      S_CONV: begin
        // sclk_q doubles as the slot phase: low half first, then high half
        if (half_done) begin
          if (!sclk_q) begin
            sclk_rise = 1'b1;
          end else if (slot_q == 4'd15) begin
            end_conv = 1'b1;
            state_d  = S_QUIET;
          end else begin
            sclk_fall = 1'b1;
          end
        end
      end
      S_QUIET: begin
        if (quiet_cnt_q == QW'(QUIET_CYC - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (period_cnt_q == '0) begin
          if (ENABLE) begin
            state_d    = S_CONV;
            start_conv = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      div_cnt_q    <= '0;
      slot_q       <= '0;
      period_cnt_q <= '0;
      quiet_cnt_q  <= '0;
      sh0_q        <= '0;
      sh1_q        <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      commit_q     <= 1'b0;
    end else begin
      commit_q <= end_conv;

      if (start_conv)
        period_cnt_q <= PER_W'(SAMPLE_PERIOD - 1);
      else if (state_q != S_IDLE && period_cnt_q != '0)
        period_cnt_q <= period_cnt_q - PER_W'(1);

      if (start_conv || half_done)
        div_cnt_q <= '0;
      else if (state_q == S_CONV)
        div_cnt_q <= div_cnt_q + DIV_W'(1);

      if (start_conv) begin
        cs_n_q <= 1'b0;
        sclk_q <= 1'b0;
        slot_q <= '0;
      end else if (sclk_rise) begin
        sclk_q <= 1'b1;
        sh0_q  <= {sh0_q[14:0], ADC_D0};
        sh1_q  <= {sh1_q[14:0], ADC_D1};
      end else if (sclk_fall) begin
        sclk_q <= 1'b0;
        slot_q <= slot_q + 4'd1;
      end else if (end_conv) begin
        cs_n_q <= 1'b1;
      end

      if (end_conv)
        quiet_cnt_q <= '0;
      else if (state_q == S_QUIET)
        quiet_cnt_q <= quiet_cnt_q + QW'(1);
    end
  end

  // Leading-zero nibble is checked but never forwarded
  assign lead_err      = (|sh0_q[15:12]) | (|sh1_q[15:12]);
  assign word          = {4'h0, sh1_q[11:0], 4'h0, sh0_q[11:0]};
  assign xfer          = valid_q && SAMPLE_READY;
  assign overrun_set   = commit_q && valid_q && !SAMPLE_READY;
  assign frame_err_set = commit_q && lead_err;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      count_q     <= '0;
    end else begin
      if (commit_q) begin
        data_q  <= C_DATA_WIDTH'(word);
        valid_q <= 1'b1;
        count_q <= count_q + 16'd1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      if (overrun_set)      overrun_q <= 1'b1;
      else if (CLEAR_FLAGS) overrun_q <= 1'b0;

      if (frame_err_set)    frame_err_q <= 1'b1;
      else if (CLEAR_FLAGS) frame_err_q <= 1'b0;
    end
  end

  assign ADC_CS_N     = cs_n_q;
  assign ADC_SCLK     = sclk_q;
  assign SAMPLE_DATA  = data_q;
  assign SAMPLE_VALID = valid_q;
  assign OVERRUN      = overrun_q;
  assign FRAME_ERR    = frame_err_q;
  assign SAMPLE_COUNT = count_q;

endmodule
